alu_pipe_stream: RTL and testbench
==================================

// Module: alu_pipe_stream
// PURPOSE
// - Parametrised successor to the 8-bit push/stop streaming ALU: WIDTH-bit operands, 8 ops (3-bit ctl).
// - Two-stage pipeline (operand register -> compute -> result FIFO) with credit-based input backpressure.
// - Sits between an operand producer (pushin/stopout) and a result consumer (pushout/stopin); lossless, in-order.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (>=2)
// - DEPTH  4  result FIFO entries (power of 2, >=2)
// PORTS
// - clk      in   1            single clock, all logic on posedge
// - rst      in   1            synchronous, active-high reset
// - pushin   in   1            operand valid from producer
// - stopout  out  1            backpressure to producer; input accepted only when pushin && !stopout
// - a        in   WIDTH        operand A
// - b        in   WIDTH        operand B
// - ci       in   1            carry/borrow/shift-in
// - ctl      in   3            opcode (alu_pkg::alu_op_e)
// - z        out  WIDTH        result at FIFO head; 0 when pushout=0
// - cout     out  1            carry/borrow/shift-out at FIFO head; 0 when pushout=0
// - pushout  out  1            result valid; result consumed when pushout && !stopin
// - stopin   in   1            stall from consumer
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): S1 valid cleared, FIFO emptied (rd/wr ptr=0, count=0); next cycle
//   pushout=0, z=0, cout=0, stopout=0. In-flight and buffered results are discarded, never emitted.
// - Stage 1: accept at edge N latches a,b,ci,ctl into S1, s1_valid=1; else s1_valid=0.
// - Stage 2: when s1_valid, compute from S1 and write FIFO at edge N+1; pushout=1 after edge N+1 (latency 2).
// - Ops (W=WIDTH, arithmetic on W+1 bits):
//   0 ADD z=a+b+ci, cout=carry out | 1 SUB z=a-b-ci, cout=1 iff borrow (a < b+ci)
//   2 AND, 3 OR, 4 XOR: cout=0 | 5 SHL z={a[W-2:0],ci}, cout=a[W-1]
//   6 SHR z={ci,a[W-1:1]}, cout=a[0] | 7 PASSA z=a, cout=0
// - Credit rule: stopout = (count + s1_valid) >= DEPTH, from registered state only (no combinational
//   path from pushin/stopin). FIFO can therefore never overflow; S2 never stalls.
// - Conservative: a same-cycle pop does NOT lower stopout; the freed slot is visible the following cycle.
// - Pop: pushout && !stopin at edge advances rd ptr, count-1. Push with simultaneous pop: count unchanged.
// - Empty FIFO: pushout=0 regardless of stopin; stopin may toggle freely. Pointers wrap modulo DEPTH.
// - z/cout stable while pushout && stopin (head held until consumed).
// - Full throughput: one op accepted and one result emitted per cycle when stopin=0.
// - X on a/b/ci/ctl ignored when not accepted; no state change from pushin while stopout=1.
// STRUCTURE
// - alu_pkg: typedef enum logic [2:0] alu_op_e {ADD,SUB,AND,OR,XOR,SHL,SHR,PASSA}; typedef for result
//   struct {z,cout} parameterised via WIDTH in users; shared with bench scoreboard model.
// - Sub-module alu_result_fifo #(WIDTH+1, DEPTH): sync FIFO, push/pop/count/head, sync reset.
// - Top: S1 register, combinational compute function (in alu_pkg), credit compare, output zero-gating.
// TESTING (WIDTH=8, DEPTH=4 unless noted)
// - ADD a=FF b=01 ci=0 accepted edge N -> after edge N+2... precisely: pushout=1 after edge N+1, z=00 cout=1.
// - SUB a=05 b=07 ci=0 -> z=FE cout=1; SUB a=07 b=05 ci=1 -> z=01 cout=0.
// - SHL a=81 ci=1 -> z=03 cout=1; SHR a=81 ci=0 -> z=40 cout=1; AND a=F0 b=3C -> z=30 cout=0.
// - stopin=1, pushin=1 six cycles -> exactly 4 accepted, stopout=1 from cycle after 4th accept;
//   stopin=0 -> 4 results in issue order, then remaining 2 accepted, nothing lost or duplicated.
// - Full FIFO, stopin=0 one cycle with pushin=1 -> that cycle stopout=1 (no accept), next cycle stopout=0.
// - 3 results buffered + 1 in S1, rst=1 one cycle -> next cycle pushout=0, stopout=0, z=0; no stale
//   result ever emitted afterwards; random push/stop traffic vs alu_pkg model, WIDTH=16 DEPTH=8 variant.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, result record and the shared ALU compute function.
// The compute function works on a fixed maximum width and is told the real
// operand width at the call site, so every WIDTH instance shares one body.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    SHL   = 3'd5,
    SHR   = 3'd6,
    PASSA = 3'd7
  } alu_op_e;

  // Widest operand the compute function supports.
  localparam int MAXW = 64;
  // Index widths for the MAXW+1 carry vector and the MAXW operand vector.
  localparam int IW = $clog2(MAXW + 1);
  localparam int SW = $clog2(MAXW);

  // Result record; users keep the low WIDTH bits of z.
  typedef struct packed {
    logic            cout;
    logic [MAXW-1:0] z;
  } alu_res_t;

  // Evaluate one op at operand width w (2..MAXW). Bits of a/b above w are ignored.
  function automatic alu_res_t alu_compute(
    input alu_op_e         op,
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input logic            ci,
    input int unsigned     w
  );
    alu_res_t        r;
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] am;
    logic [MAXW-1:0] bm;
    logic [MAXW-1:0] ci_ext;
    logic [MAXW:0]   wide;
    r      = '{cout: 1'b0, z: {MAXW{1'b0}}};
    mask   = {MAXW{1'b1}} >> (MAXW - w);
    am     = a & mask;
    bm     = b & mask;
    ci_ext = {{(MAXW-1){1'b0}}, ci};
    wide   = {(MAXW+1){1'b0}};
    case (op)
      ADD: begin
        // Carry out lands on bit w of the widened sum.
        wide   = {1'b0, am} + {1'b0, bm} + {1'b0, ci_ext};
        r.z    = wide[MAXW-1:0] & mask;
        r.cout = wide[IW'(w)];
      end
      SUB: begin
        // A borrow wraps the widened difference, which sets bit w.
        wide   = {1'b0, am} - {1'b0, bm} - {1'b0, ci_ext};
        r.z    = wide[MAXW-1:0] & mask;
        r.cout = wide[IW'(w)];
      end
      AND: begin
        r.z    = am & bm;
        r.cout = 1'b0;
      end
      OR: begin
        r.z    = am | bm;
        r.cout = 1'b0;
      end
      XOR: begin
        r.z    = am ^ bm;
        r.cout = 1'b0;
      end
      SHL: begin
        r.z    = ((am << 32'd1) | ci_ext) & mask;
        r.cout = am[SW'(w - 32'd1)];
      end
      SHR: begin
        r.z    = (am >> 32'd1) | (ci_ext << (w - 32'd1));
        r.cout = am[0];
      end
      PASSA: begin
        r.z    = am;
        r.cout = 1'b0;
      end
      default: begin
        r.z    = am;
        r.cout = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: synchronous result FIFO with push/pop, occupancy count and
// a combinational view of the head entry. The caller guarantees no push when
// full and no pop when empty (the credit rule in the top ensures the former).
module alu_result_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           din,
  input  logic                    pop,
  output logic [DW-1:0]           head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry and occupancy straight from registered state.
  always_comb begin
    head  = mem_r[rd_ptr_r];
    count = count_r;
  end

endmodule

// File: rtl/alu_pipe_stream.sv
// alu_pipe_stream: two-stage streaming ALU. Stage 1 registers the accepted
// operands, stage 2 computes and writes straight into the result FIFO.
// Backpressure is credit based: the producer is stopped once the FIFO plus
// the stage-1 slot could fill the FIFO, so stage 2 never has to stall.
module alu_pipe_stream
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushin,
  output logic             stopout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [2:0]       ctl,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             pushout,
  input  logic             stopin
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Stage 1 operand register
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic             s1_ci_r;
  alu_op_e          s1_op_r;

  // Stage 2 / FIFO interface
  alu_res_t         res_s;
  logic [WIDTH:0]   fifo_din_s;
  logic [WIDTH:0]   head_s;
  logic [CW-1:0]    count_s;
  logic [CW:0]      credit_s;
  logic             stop_s;
  logic             accept_s;
  logic             have_s;
  logic             pop_s;
  logic             unused_res_s;

  // Credit compare and handshake decode, all from registered state except the
  // final AND with pushin/stopin, which never feeds back into stopout.
  always_comb begin
    credit_s = {1'b0, count_s} + {{CW{1'b0}}, s1_valid_r};
    stop_s   = (credit_s >= DEPTH_C);
    have_s   = (count_s != {CW{1'b0}});
    accept_s = pushin & ~stop_s;
    pop_s    = have_s & ~stopin;
  end

  // Stage 1: latch operands on accept; valid drops whenever nothing is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_ci_r    <= 1'b0;
      s1_op_r    <= PASSA;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r  <= a;
        s1_b_r  <= b;
        s1_ci_r <= ci;
        s1_op_r <= alu_op_e'(ctl);
      end
    end
  end

  // Stage 2: compute from the stage-1 register and pack {cout, z} for the FIFO.
  always_comb begin
    res_s        = alu_compute(s1_op_r, MAXW'(s1_a_r), MAXW'(s1_b_r), s1_ci_r, WIDTH);
    fifo_din_s   = {res_s.cout, res_s.z[WIDTH-1:0]};
    unused_res_s = ^res_s;
  end

  alu_result_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid_r),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .head  (head_s),
    .count (count_s)
  );

  // Output drive: head shown only while valid, zeros otherwise.
  always_comb begin
    stopout = stop_s;
    pushout = have_s;
    if (have_s) begin
      z    = head_s[WIDTH-1:0];
      cout = head_s[WIDTH];
    end else begin
      z    = {WIDTH{1'b0}};
      cout = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_stream.sv
// tb_alu_pipe_stream: directed vector table, hand-written backpressure and
// reset sequences on an 8-bit/4-deep instance, plus random push/stop traffic
// on a 16-bit/8-deep instance. Both instances are shadowed by a scoreboard.
module tb_alu_pipe_stream;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       pushin8 = 1'b0, stopin8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic [2:0] ctl8 = 3'd0;
  logic       stopout8, pushout8, cout8;
  logic [7:0] z8;

  // 16-bit instance
  logic        pushin16 = 1'b0, stopin16 = 1'b0, ci16 = 1'b0;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
  logic [2:0]  ctl16 = 3'd0;
  logic        stopout16, pushout16, cout16;
  logic [15:0] z16;

  alu_pipe_stream #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .pushin(pushin8), .stopout(stopout8),
    .a(a8), .b(b8), .ci(ci8), .ctl(ctl8),
    .z(z8), .cout(cout8), .pushout(pushout8), .stopin(stopin8)
  );

  alu_pipe_stream #(.WIDTH(16), .DEPTH(8)) dut16 (
    .clk(clk), .rst(rst), .pushin(pushin16), .stopout(stopout16),
    .a(a16), .b(b16), .ci(ci16), .ctl(ctl16),
    .z(z16), .cout(cout16), .pushout(pushout16), .stopin(stopin16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain integer arithmetic at width w (<=16).
  function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci, input int w);
    longint ai, bi, cii, mask, s;
    logic cc;
    ai = longint'(a); bi = longint'(b); cii = longint'(ci);
    mask = (longint'(1) << w) - 1;
    s = 0; cc = 1'b0;
    case (op)
      3'd0: begin s = ai + bi + cii; cc = ((s >> w) & 1) != 0; end
      3'd1: begin s = ai - bi - cii; cc = ai < (bi + cii); end
      3'd2: s = ai & bi;
      3'd3: s = ai | bi;
      3'd4: s = ai ^ bi;
      3'd5: begin s = (ai << 1) | cii; cc = ((ai >> (w - 1)) & 1) != 0; end
      3'd6: begin s = (ai >> 1) | (cii << (w - 1)); cc = (ai & 1) != 0; end
      default: s = ai;
    endcase
    s = s & mask;
    return {cc, 16'(s)};
  endfunction

  // Scoreboards: queue holds every accepted, not yet consumed result in order;
  // the last entry sits in stage 1 when s1p is set.
  bit         sb_on = 1'b0;
  logic [8:0] q8[$];
  bit         s1p8 = 1'b0;
  int         fc8;
  bit         es8;
  logic [8:0] hd8;
  logic [16:0] m8;
  logic [16:0] q16[$];
  bit          s1p16 = 1'b0;
  int          fc16;
  bit          es16;
  logic [16:0] hd16;

  // Scoreboard for the 8-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_on) begin
      fc8 = q8.size() - int'(s1p8);
      es8 = q8.size() >= 4;
      hd8 = (fc8 > 0) ? q8[0] : 9'h000;
      chk("sb8_stopout", 32'(stopout8), 32'(es8));
      chk("sb8_pushout", 32'(pushout8), 32'(fc8 > 0));
      chk("sb8_z", 32'(z8), 32'(hd8[7:0]));
      chk("sb8_cout", 32'(cout8), 32'(hd8[8]));
      if (rst) begin
        q8.delete();
        s1p8 = 1'b0;
      end else begin
        if (fc8 > 0 && !stopin8) void'(q8.pop_front());
        if (pushin8 && !es8) begin
          m8 = model(ctl8, 16'(a8), 16'(b8), ci8, 8);
          q8.push_back({m8[16], m8[7:0]});
          s1p8 = 1'b1;
        end else begin
          s1p8 = 1'b0;
        end
      end
    end
  end

  // Scoreboard for the 16-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_on) begin
      fc16 = q16.size() - int'(s1p16);
      es16 = q16.size() >= 8;
      hd16 = (fc16 > 0) ? q16[0] : 17'h00000;
      chk("sb16_stopout", 32'(stopout16), 32'(es16));
      chk("sb16_pushout", 32'(pushout16), 32'(fc16 > 0));
      chk("sb16_z", 32'(z16), 32'(hd16[15:0]));
      chk("sb16_cout", 32'(cout16), 32'(hd16[16]));
      if (rst) begin
        q16.delete();
        s1p16 = 1'b0;
      end else begin
        if (fc16 > 0 && !stopin16) void'(q16.pop_front());
        if (pushin16 && !es16) begin
          q16.push_back(model(ctl16, a16, b16, ci16, 16));
          s1p16 = 1'b1;
        end else begin
          s1p16 = 1'b0;
        end
      end
    end
  end

  typedef struct {
    alu_op_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] ez;
    logic       ec;
  } vec_t;

  vec_t vecs[14];
  int   idx;
  int   out_next;
  int   acc;
  bit   leak;

  initial begin
    vecs[0]  = '{ADD,   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{SUB,   8'h05, 8'h07, 1'b0, 8'hFE, 1'b1};
    vecs[2]  = '{SUB,   8'h07, 8'h05, 1'b1, 8'h01, 1'b0};
    vecs[3]  = '{SHL,   8'h81, 8'h00, 1'b1, 8'h03, 1'b1};
    vecs[4]  = '{SHR,   8'h81, 8'h00, 1'b0, 8'h40, 1'b1};
    vecs[5]  = '{AND,   8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[6]  = '{OR,    8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0};
    vecs[7]  = '{XOR,   8'hAA, 8'hFF, 1'b1, 8'h55, 1'b0};
    vecs[8]  = '{PASSA, 8'h5A, 8'h12, 1'b1, 8'h5A, 1'b0};
    vecs[9]  = '{ADD,   8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{ADD,   8'h10, 8'h20, 1'b1, 8'h31, 1'b0};
    vecs[11] = '{SUB,   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[12] = '{SUB,   8'h05, 8'h04, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{SHR,   8'h02, 8'h00, 1'b1, 8'h81, 1'b0};

    // Reset state
    step(); step();
    rst = 1'b0;
    sb_on = 1'b1;
    chk("rst_pushout", 32'(pushout8), 32'd0);
    chk("rst_stopout", 32'(stopout8), 32'd0);
    chk("rst_z", 32'(z8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);

    // Vector table: one op at a time, checking the two-cycle latency
    foreach (vecs[i]) begin
      ctl8 = vecs[i].op; a8 = vecs[i].a; b8 = vecs[i].b; ci8 = vecs[i].ci;
      pushin8 = 1'b1;
      step();
      pushin8 = 1'b0;
      chk("vec_lat1_pushout", 32'(pushout8), 32'd0);
      step();
      chk("vec_pushout", 32'(pushout8), 32'd1);
      chk("vec_z", 32'(z8), 32'(vecs[i].ez));
      chk("vec_cout", 32'(cout8), 32'(vecs[i].ec));
      step();
      chk("vec_consumed", 32'(pushout8), 32'd0);
    end

    // Stalled consumer, producer holds each item until accepted
    stopin8 = 1'b1; ctl8 = PASSA; b8 = 8'h00; ci8 = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      pushin8 = 1'b1;
      a8 = 8'(idx + 1);
      if (!stopout8) idx++;
      step();
    end
    chk("bp_accepts", 32'(idx), 32'd4);
    chk("bp_stopout", 32'(stopout8), 32'd1);

    // Full FIFO: releasing the consumer does not lower stopout this cycle
    stopin8 = 1'b0; pushin8 = 1'b1; a8 = 8'(idx + 1);
    chk("full_stop_same", 32'(stopout8), 32'd1);
    chk("full_head", 32'(z8), 32'h01);
    out_next = 2;
    step();
    chk("full_stop_next", 32'(stopout8), 32'd0);

    // Drain: remaining items accepted, results come out in issue order
    for (int c = 0; c < 20 && out_next < 7; c++) begin
      pushin8 = (idx < 6);
      a8 = 8'(idx + 1);
      if (pushout8) begin
        chk("drain_order", 32'(z8), 32'(out_next));
        out_next++;
      end
      if (pushin8 && !stopout8) idx++;
      step();
    end
    pushin8 = 1'b0;
    chk("drain_accepts", 32'(idx), 32'd6);
    chk("drain_outputs", 32'(out_next), 32'd7);

    // Reset with three results buffered and one in stage 1
    stopin8 = 1'b1; ctl8 = ADD; b8 = 8'h10;
    for (int c = 0; c < 4; c++) begin
      pushin8 = 1'b1;
      a8 = 8'(8'h20 + 8'(c));
      chk("pre_rst_stopout", 32'(stopout8), 32'd0);
      step();
    end
    pushin8 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pushout", 32'(pushout8), 32'd0);
    chk("mid_rst_stopout", 32'(stopout8), 32'd0);
    chk("mid_rst_z", 32'(z8), 32'd0);
    stopin8 = 1'b0;
    leak = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (pushout8) leak = 1'b1;
      step();
    end
    chk("no_stale_result", 32'(leak), 32'd0);

    // Random push/stop traffic on the wide instance
    for (int c = 0; c < 600; c++) begin
      pushin16 = ($urandom_range(0, 3) != 0);
      stopin16 = (c % 150 < 40) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ci16 = 1'($urandom_range(0, 1));
      ctl16 = 3'($urandom_range(0, 7));
      step();
    end
    pushin16 = 1'b0;
    stopin16 = 1'b0;
    for (int c = 0; c < 15; c++) step();
    chk("rand_drained", 32'(pushout16), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
